// File: rtl/axi4_mult_pkg.sv
// axi4_mult_pkg: shared types and constants for the AXI4 multiplier master.
// Beat counts are derived from operand and beat widths.
package axi4_mult_pkg;

    localparam int A_IDX = 0;
    localparam int B_IDX = 1;
    localparam int R_IDX = 2;

    localparam logic OK = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        AW_A,
        W_A,
        B_A,
        AW_B,
        W_B,
        B_B,
        AR,
        R,
        RSP
    } state_t;

    function automatic int calc_nw(input int sz, input int dsz);
        return sz / dsz;
    endfunction

    function automatic int calc_nr(input int sz, input int dsz);
        return (2 * sz) / dsz;
    endfunction

endpackage

// File: rtl/axi4_mult_master.sv
// axi4_mult_master: writes operands a and b to the multiplier slave,
// reads back the double-width product and returns it on rsp_*.
module axi4_mult_master #(
    parameter int SZ    = 32,
    parameter int ASZ   = 2,
    parameter int DSZ   = 8,
    parameter int A_IDX = axi4_mult_pkg::A_IDX,
    parameter int B_IDX = axi4_mult_pkg::B_IDX,
    parameter int R_IDX = axi4_mult_pkg::R_IDX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [SZ-1:0] cmd_a,
    input  logic [SZ-1:0] cmd_b,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [2*SZ-1:0] rsp_res,
    output logic          rsp_err,
    output logic [ASZ-1:0] awaddr,
    output logic          awvalid,
    input  logic          awready,
    output logic [DSZ-1:0] wdata,
    output logic          wvalid,
    output logic          wlast,
    input  logic          wready,
    input  logic          bresp,
    input  logic          bvalid,
    output logic          bready,
    output logic [ASZ-1:0] araddr,
    output logic          arvalid,
    input  logic          arready,
    input  logic [DSZ-1:0] rdata,
    input  logic          rvalid,
    input  logic          rlast,
    input  logic          rresp,
    output logic          rready
);
    import axi4_mult_pkg::*;

    localparam int NW = calc_nw(SZ, DSZ);
    localparam int NR = calc_nr(SZ, DSZ);
    localparam int CW = $clog2(NR + 1);
    localparam logic [CW-1:0] NW_LAST = CW'(NW - 1);
    localparam logic [CW-1:0] NR_LAST = CW'(NR - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SZ-1:0]   sh_q, sh_d;
    logic [SZ-1:0]   b_q, b_d;
    logic [2*SZ-1:0] res_q, res_d;
    logic            err_q, err_d;
    logic [ASZ-1:0]  awaddr_q, awaddr_d;
    logic [ASZ-1:0]  araddr_q, araddr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            b_q      <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            awaddr_q <= '0;
            araddr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            b_q      <= b_d;
            res_q    <= res_d;
            err_q    <= err_d;
            awaddr_q <= awaddr_d;
            araddr_q <= araddr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        b_d      = b_q;
        res_d    = res_q;
        err_d    = err_q;
        awaddr_d = awaddr_q;
        araddr_d = araddr_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    sh_d     = cmd_a;
                    b_d      = cmd_b;
                    err_d    = 1'b0;
                    res_d    = '0;
                    awaddr_d = ASZ'(A_IDX);
                    state_d  = AW_A;
                end
            end
            AW_A, AW_B: begin
                if (awready) begin
                    cnt_d   = '0;
                    state_d = (state_q == AW_A) ? W_A : W_B;
                end
            end
            W_A, W_B: begin
                // sh_q low beat is always the current wdata
                if (wready) begin
                    sh_d  = sh_q >> DSZ;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == NW_LAST) begin
                        state_d = (state_q == W_A) ? B_A : B_B;
                    end
                end
            end
            B_A, B_B: begin
                if (bvalid) begin
                    if (bresp != OK) begin
                        err_d   = 1'b1;
                        res_d   = '0;
                        state_d = RSP;
                    end else if (state_q == B_A) begin
                        awaddr_d = ASZ'(B_IDX);
                        sh_d     = b_q;
                        state_d  = AW_B;
                    end else begin
                        araddr_d = ASZ'(R_IDX);
                        state_d  = AR;
                    end
                end
            end
            AR: begin
                if (arready) begin
                    cnt_d   = '0;
                    state_d = R;
                end
            end
            R: begin
                if (rvalid) begin
                    res_d[DSZ*int'(cnt_q) +: DSZ] = rdata;
                    if (rresp != OK) begin
                        err_d = 1'b1;
                    end
                    // rlast must coincide with the final beat, never earlier
                    if (rlast != (cnt_q == NR_LAST)) begin
                        err_d = 1'b1;
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == NR_LAST) begin
                        state_d = RSP;
                    end
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign awvalid   = (state_q == AW_A) || (state_q == AW_B);
    assign awaddr    = awaddr_q;
    assign wvalid    = (state_q == W_A) || (state_q == W_B);
    assign wlast     = wvalid && (cnt_q == NW_LAST);
    assign wdata     = sh_q[DSZ-1:0];
    assign bready    = (state_q == B_A) || (state_q == B_B);
    assign arvalid   = (state_q == AR);
    assign araddr    = araddr_q;
    assign rready    = (state_q == R);
    assign rsp_valid = (state_q == RSP);
    assign rsp_res   = res_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_axi4_mult_master.sv
// tb_axi4_mult_master: directed tests against a behavioural AXI4 slave
// that multiplies the written operands and can stall or inject errors.
module tb_axi4_mult_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_res;
    logic        rsp_err;
    logic [1:0]  awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [7:0]  wdata;
    logic        wvalid;
    logic        wlast;
    logic        wready = 1'b0;
    logic        bresp = 1'b0;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [1:0]  araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [7:0]  rdata = '0;
    logic        rvalid = 1'b0;
    logic        rlast = 1'b0;
    logic        rresp = 1'b0;
    logic        rready;

    axi4_mult_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_err(rsp_err),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wlast(wlast), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast),
        .rresp(rresp), .rready(rready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // slave configuration, written by the stimulus only
    bit          stall_en = 0;
    bit          bresp_bad = 0;
    int          rresp_bad_beat = -1;
    int          rlast_early_beat = -1;
    logic [31:0] cur_a = '0;
    logic [31:0] cur_b = '0;

    // slave state
    int          aw_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int          wt[5];
    bit          arm[5];
    int          wk = 0, rk = 0, r_left = 0;
    bit          b_owed = 0;
    logic [1:0]  cur_aw = '0, next_aw = '0;
    logic [31:0] wa = '0, wb = '0;
    logic [63:0] prod = '0;
    bit          st_aw = 0, st_w = 0;
    logic [1:0]  p_awaddr = '0;
    logic [7:0]  p_wdata = '0;
    logic        p_wlast = 1'b0;
    logic [31:0] op;

    function automatic bit gate(input int ch, input bit want);
        if (!want) return 1'b0;
        if (!arm[ch]) begin
            arm[ch] = 1'b1;
            wt[ch] = stall_en ? int'($urandom_range(0, 3)) : 0;
        end
        if (wt[ch] > 0) begin
            wt[ch]--;
            return 1'b0;
        end
        arm[ch] = 1'b0;
        return 1'b1;
    endfunction

    // Drives at negedge; handshakes decided here complete at the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 0;
            arready = 0; rvalid = 0; rdata = '0; rlast = 0; rresp = 0;
            for (int i = 0; i < 5; i++) begin
                arm[i] = 0;
                wt[i] = 0;
            end
            wk = 0; rk = 0; r_left = 0; b_owed = 0;
            next_aw = 2'd0; st_aw = 0; st_w = 0;
        end else begin
            if (st_aw)
                chk("aw_hold", 64'({awvalid, awaddr}), 64'({1'b1, p_awaddr}));
            if (st_w)
                chk("w_hold", 64'({wvalid, wlast, wdata}),
                    64'({1'b1, p_wlast, p_wdata}));
            awready = gate(0, awvalid);
            wready  = gate(1, wvalid);
            bvalid  = gate(2, b_owed);
            bresp   = !(bresp_bad && cur_aw == 2'd0);
            arready = gate(3, arvalid);
            rvalid  = gate(4, r_left > 0);
            rdata   = (r_left > 0) ? prod[8*rk +: 8] : 8'h00;
            rresp   = (rk != rresp_bad_beat);
            rlast   = (rk == 7) || (rk == rlast_early_beat);
            st_aw = awvalid && !awready;
            p_awaddr = awaddr;
            st_w = wvalid && !wready;
            p_wdata = wdata;
            p_wlast = wlast;
            if (awvalid && awready) begin
                chk("awaddr", 64'(awaddr), 64'(next_aw));
                cur_aw = awaddr;
                wk = 0;
                aw_cnt++;
            end
            if (wvalid && wready) begin
                op = (cur_aw == 2'd0) ? cur_a : cur_b;
                chk("wdata", 64'(wdata), 64'(op[8*wk +: 8]));
                chk("wlast", 64'(wlast), 64'(wk == 3));
                if (cur_aw == 2'd0) wa[8*wk +: 8] = wdata;
                else wb[8*wk +: 8] = wdata;
                wk++;
                if (wk == 4) begin
                    wk = 0;
                    b_owed = 1;
                end
            end
            if (bvalid && bready) begin
                b_owed = 0;
                next_aw = (cur_aw == 2'd0 && bresp) ? 2'd1 : 2'd0;
            end
            if (arvalid && arready) begin
                chk("araddr", 64'(araddr), 64'd2);
                ar_cnt++;
                prod = 64'(wa) * 64'(wb);
                r_left = 8;
                rk = 0;
            end
            if (rvalid && rready) begin
                rk++;
                r_left--;
                r_cnt++;
            end
        end
    end

    task automatic chk_rst_outs(input string tag);
        chk({tag, "_ctl"},
            64'({awvalid, wvalid, wlast, bready, arvalid, rready,
                 rsp_valid, rsp_err, cmd_ready}),
            64'(9'b000000001));
        chk({tag, "_dat"}, 64'({awaddr, araddr, wdata}), 64'd0);
        chk({tag, "_res"}, rsp_res, 64'd0);
    endtask

    task automatic run_cmd(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res,
                           input bit exp_err, input int exp_lat,
                           input int hold);
        int n;
        cur_a = a;
        cur_b = b;
        @(posedge clk); #1;
        chk({tag, "_cmdrdy"}, 64'(cmd_ready), 64'd1);
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rsp_valid) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
            rsp_ready = 1'b1;
            return;
        end
        if (exp_lat >= 0) chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_res"}, rsp_res, exp_res);
        chk({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold"}, 64'({rsp_valid, cmd_ready, rsp_err}),
                64'({1'b1, 1'b0, exp_err}));
            chk({tag, "_holdres"}, rsp_res, exp_res);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_done"}, 64'({rsp_valid, cmd_ready}), 64'(2'b01));
    endtask

    int aw0, ar0, r0, n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_rst_outs("reset");
        rst = 1'b0;

        run_cmd("nominal", 32'h0000_0003, 32'h0000_0005,
                64'h0000_0000_0000_000F, 0, 21, 0);
        run_cmd("pat_hi", 32'h8000_0000, 32'h0000_0002,
                64'h0000_0001_0000_0000, 0, 21, 0);
        run_cmd("pat_mid", 32'h0001_0000, 32'h0000_FFFF,
                64'h0000_0000_FFFF_0000, 0, 21, 0);
        run_cmd("pat_zero", 32'hDEAD_BEEF, 32'h0000_0000,
                64'h0, 0, 21, 0);

        stall_en = 1;
        run_cmd("stall", 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                64'hFFFF_FFFE_0000_0001, 0, -1, 0);
        run_cmd("stall2", 32'h0000_0100, 32'h0000_0010,
                64'h0000_0000_0000_1000, 0, -1, 0);
        stall_en = 0;

        aw0 = aw_cnt; ar0 = ar_cnt;
        bresp_bad = 1;
        run_cmd("werr", 32'h0000_0007, 32'h0000_0009, 64'h0, 1, 6, 0);
        bresp_bad = 0;
        chk("werr_aw", 64'(aw_cnt - aw0), 64'd1);
        chk("werr_ar", 64'(ar_cnt - ar0), 64'd0);

        r0 = r_cnt;
        rresp_bad_beat = 4;
        run_cmd("rresp", 32'h0000_0003, 32'h0000_0005,
                64'h0000_0000_0000_000F, 1, 21, 0);
        rresp_bad_beat = -1;
        chk("rresp_beats", 64'(r_cnt - r0), 64'd8);

        r0 = r_cnt;
        rlast_early_beat = 5;
        run_cmd("rlast", 32'h0000_0003, 32'h0000_0005,
                64'h0000_0000_0000_000F, 1, 21, 0);
        rlast_early_beat = -1;
        chk("rlast_beats", 64'(r_cnt - r0), 64'd8);

        run_cmd("rsphold", 32'h0000_0002, 32'h0000_0003,
                64'h0000_0000_0000_0006, 0, 21, 5);

        // abandon a command while operand b is being written
        aw0 = aw_cnt;
        cur_a = 32'h1111_1111;
        cur_b = 32'h2222_2222;
        @(posedge clk); #1;
        cmd_a = cur_a;
        cmd_b = cur_b;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!(wvalid && aw_cnt - aw0 == 2) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wb_reached", 64'(wvalid && aw_cnt - aw0 == 2), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_rst_outs("midrst");
        rst = 1'b0;
        run_cmd("postrst", 32'h0000_0010, 32'h0000_0010,
                64'h0000_0000_0000_0100, 0, 21, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
